// File: rtl/mul_iter_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Holds the FSM state encoding, the ALUOp code this unit takes over
// from the ALU, and the default operand/counter widths.
package mul_iter_unit_pkg;

  // Default operand/result width and the iteration counter width.
  // The counter must be able to hold the value WIDTH.
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  // ALUOp code for multiply; the decoder routes this op here instead of the ALU.
  localparam logic [2:0] ALU_MUL = 3'd4;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mulState_e;

endpackage

// File: rtl/mul_iter_unit_step.sv
// One combinational shift-add multiply iteration.
// Ports:
//   acc_i / acc_o       partial product in / out
//   mcand_i / mcand_o   multiplicand in / out (shifted left by one)
//   mplier_i / mplier_o multiplier in / out (shifted right by one)
// The low multiplier bit decides whether the current multiplicand is
// added into the accumulator; the sum wraps at WIDTH bits.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  // Conditional add, then advance both operands by one bit position.
  always_comb begin
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/mul_iter_unit.sv
// Multi-cycle shift-add multiply unit for the EX stage.
// Runs a fixed WIDTH iterations per multiply, so hazard logic can stall
// on busy_out and pick up the truncated product when done_out pulses.
// Ports:
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-low reset
//   start_in  request a multiply (accepted in IDLE or DONE)
//   kill_in   synchronous abort, wins over start_in
//   Data1_in  multiplicand, sampled on accept
//   Data2_in  multiplier, sampled on accept
//   busy_out  high while iterating
//   done_out  high for the single cycle after the last iteration
//   Data_out  low WIDTH bits of the product, held between operations
module mul_iter_unit
  import mul_iter_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_in,
  input  logic             kill_in,
  input  logic [WIDTH-1:0] Data1_in,
  input  logic [WIDTH-1:0] Data2_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] Data_out
);

  mulState_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] data_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mcand_d;
  logic [WIDTH-1:0] mplier_d;
  logic             lastIter;

  mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mplier_i(mplier_q),
    .acc_o   (acc_d),
    .mcand_o (mcand_d),
    .mplier_o(mplier_d)
  );

  // The iteration taken while the counter sits at WIDTH-1 is the final one,
  // so its result (acc_d) is what gets published, not acc_q.
  assign lastIter = (cnt_q == CNT_W'(WIDTH - 1));

  // Control FSM with registered outputs. Kill is checked ahead of the state
  // case so it overrides any start in the same cycle and never raises done.
  // Accepting from DONE goes straight back to BUSY, giving back-to-back
  // issue without an idle bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
    end else if (kill_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_in) begin
            state_q  <= BUSY;
            mcand_q  <= Data1_in;
            mplier_q <= Data2_in;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + 1'b1;
          if (lastIter) begin
            state_q <= DONE;
            data_q  <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_out = busy_q;
  assign done_out = done_q;
  assign Data_out = data_q;

endmodule
